// File: rtl/cnn_pkg.sv
// Shared helpers for the convolutional front end: counter sizing and window geometry.
package cnn_pkg;

    // Bits needed to count 0..n-1, never narrower than one bit.
    function automatic int counter_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Slice index of element (ch, r, c) inside the flat window bus; (0,0,0) is the MSB slice.
    function automatic int window_slice(input int ch, input int r, input int c,
                                        input int f, input int channels);
        return ((channels - 1 - ch) * f + (f - 1 - r)) * f + (f - 1 - c);
    endfunction

    function automatic int windows_per_frame(input int w, input int h, input int f,
                                             input int sx, input int sy);
        return ((w - f) / sx + 1) * ((h - f) / sy + 1);
    endfunction

endpackage

// File: rtl/strided_window_generator_line_buffer.sv
// One-row delay line: reading and writing the same column address returns the
// pixel accepted exactly one image row earlier.
module line_buffer
    import cnn_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 24,
    localparam int AW   = counter_width(DEPTH)
) (
    input  logic             clk,
    input  logic             shift_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign dout = mem[addr];

    // NOTE: the storage has no reset. A row is only read into a window after the
    // current frame has rewritten it, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/strided_window_generator.sv
// Emits every strided FILTER_SIZE x FILTER_SIZE multi-channel window of a
// raster-order pixel stream as one flat registered bus.
module strided_window_generator
    import cnn_pkg::*;
#(
    parameter int D_WIDTH      = 8,
    parameter int D_CHANNELS   = 3,
    parameter int FILTER_SIZE  = 5,
    parameter int IMAGE_WIDTH  = 64,
    parameter int IMAGE_HEIGHT = 32,
    parameter int STRIDE_X     = 1,
    parameter int STRIDE_Y     = 1
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic                                                clk_en,
    input  logic                                                in_valid,
    input  logic [D_CHANNELS*D_WIDTH-1:0]                       input_data,
    output logic [D_CHANNELS*FILTER_SIZE*FILTER_SIZE*D_WIDTH-1:0] window_data,
    output logic                                                window_valid,
    output logic                                                frame_done
);

    localparam int F   = FILTER_SIZE;
    localparam int PW  = D_CHANNELS * D_WIDTH;
    localparam int CW  = counter_width(IMAGE_WIDTH);
    localparam int RW  = counter_width(IMAGE_HEIGHT);
    localparam int SXW = counter_width(STRIDE_X);
    localparam int SYW = counter_width(STRIDE_Y);

    localparam logic [CW-1:0]  COL_LAST  = CW'(IMAGE_WIDTH - 1);
    localparam logic [CW-1:0]  COL_FIRST = CW'(F - 1);
    localparam logic [RW-1:0]  ROW_LAST  = RW'(IMAGE_HEIGHT - 1);
    localparam logic [RW-1:0]  ROW_FIRST = RW'(F - 1);
    localparam logic [SXW-1:0] SX_LAST   = SXW'(STRIDE_X - 1);
    localparam logic [SYW-1:0] SY_LAST   = SYW'(STRIDE_Y - 1);

    logic           accept, col_wrap, row_wrap, emit;
    logic [CW-1:0]  col, col_inc;
    logic [RW-1:0]  row, row_inc;
    logic [SXW-1:0] sx, sx_nxt;
    logic [SYW-1:0] sy, sy_nxt;

    // tap[r] is window row r of the current column; r = F-1 is the live pixel.
    logic [PW-1:0] tap [F];
    logic [PW-1:0] win     [F][F];
    logic [PW-1:0] win_nxt [F][F];
    logic [D_CHANNELS*F*F*D_WIDTH-1:0] packed_nxt;

    assign accept   = clk_en & in_valid;
    assign col_wrap = (col == COL_LAST);
    assign row_wrap = (row == ROW_LAST);
    assign emit     = accept && (col >= COL_FIRST) && (row >= ROW_FIRST)
                      && (sx == '0) && (sy == '0);

    // Stride phases describe the pixel/row about to become current; a phase of
    // zero marks a window-aligned position, restarting at the first full column/row.
    always_comb begin
        col_inc = col + 1'b1;
        row_inc = row + 1'b1;
        sx_nxt  = sx;
        sy_nxt  = sy;
        if (col_wrap || col_inc == COL_FIRST) begin
            sx_nxt = '0;
        end else if (col_inc > COL_FIRST) begin
            sx_nxt = (sx == SX_LAST) ? '0 : sx + 1'b1;
        end
        if (row_wrap || row_inc == ROW_FIRST) begin
            sy_nxt = '0;
        end else if (row_inc > ROW_FIRST) begin
            sy_nxt = (sy == SY_LAST) ? '0 : sy + 1'b1;
        end
    end

    // NOTE: state registers take <= only; the next-state logic above uses = in
    // always_comb and gives every variable a value on every path, so no latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
            sx  <= '0;
            sy  <= '0;
        end else if (accept) begin
            col <= col_wrap ? '0 : col_inc;
            sx  <= sx_nxt;
            if (col_wrap) begin
                row <= row_wrap ? '0 : row_inc;
                sy  <= sy_nxt;
            end
        end
    end

    assign tap[F-1] = input_data;

    for (genvar k = 0; k < F - 1; k++) begin : g_line
        line_buffer #(
            .DEPTH (IMAGE_WIDTH),
            .WIDTH (PW)
        ) u_line (
            .clk      (clk),
            .shift_en (accept),
            .addr     (col),
            .din      (tap[F-1-k]),
            .dout     (tap[F-2-k])
        );
    end

    always_comb begin
        for (int r = 0; r < F; r++) begin
            for (int c = 0; c < F; c++) begin
                win_nxt[r][c] = (c < F - 1) ? win[r][c+1] : tap[r];
            end
        end
    end

    always_comb begin
        packed_nxt = '0;
        for (int ch = 0; ch < D_CHANNELS; ch++) begin
            for (int r = 0; r < F; r++) begin
                for (int c = 0; c < F; c++) begin
                    packed_nxt[window_slice(ch, r, c, F, D_CHANNELS)*D_WIDTH +: D_WIDTH] =
                        win_nxt[r][c][(D_CHANNELS-1-ch)*D_WIDTH +: D_WIDTH];
                end
            end
        end
    end

    // Window columns are data-only, like the line buffers.
    always_ff @(posedge clk) begin
        if (accept) begin
            win <= win_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            window_data  <= '0;
        end else begin
            window_valid <= emit;
            frame_done   <= accept && col_wrap && row_wrap;
            if (emit) begin
                window_data <= packed_nxt;
            end
        end
    end

endmodule
